ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one port of the dual-port block RAM (ram_dual) between two requesters.
//  Requester m0 is the J1 CPU data bus; m1 is the serial loader/debug engine.
//  Arbitration is round-robin. m1 may lock the port for bursts, bounded by BURST_MAX.
//  Tracks the RAM's 1-cycle registered read latency and returns tagged read data.
// PARAMETERS
//  LOG2ABITS  12  RAM address width; must match the attached ram_dual
//  DWIDTH     16  RAM data width; must match the attached ram_dual
//  BURST_MAX  8   max consecutive locked m1 grants while m0 waits; must be >=1
// PORTS
//  clk        in   1          rising-edge clock, shared with ram_dual
//  reset      in   1          asynchronous, active-high reset
//  m0_req     in   1          m0 access request, level; held until m0_gnt
//  m0_we      in   1          1=write, 0=read
//  m0_addr    in   LOG2ABITS  m0 address
//  m0_wdata   in   DWIDTH     m0 write data
//  m0_gnt     out  1          combinational: m0 access issued to RAM this cycle
//  m0_rvalid  out  1          registered: rdata holds m0 read result
//  m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid   as m0_*, for m1
//  m1_lock    in   1          m1 requests to retain ownership after its grant
//  ram_addr   out  LOG2ABITS  to ram_dual addrb
//  ram_wdata  out  DWIDTH     to ram_dual writeb
//  ram_we     out  1          to ram_dual web
//  ram_rdata  in   DWIDTH     from ram_dual readb
//  rdata      out  DWIDTH     = ram_rdata, pass-through; qualify with mX_rvalid
// BEHAVIOUR
//  - Reset state: m0_rvalid=m1_rvalid=0, last=1 (m0 wins first tie), burst_cnt=0, lock_own=0.
//  - While reset is high: m0_gnt=m1_gnt=0 and ram_we=0.
//  - Grant, combinational, at most one per cycle:
//      only one req -> grant it
//      both req, lock_own=1, burst_cnt<BURST_MAX -> m1
//      both req, otherwise -> requester != last
//  - Address/write mux:
//      ram_addr/ram_wdata/ram_we come from the granted requester
//      no grant -> m0 fields with ram_we forced 0
//      ram_we = granted requester's we
//  - Registered state updates on grant:
//      last <= granted id
//      lock_own <= (m1 granted && m1_lock)
//      no request pending -> state holds
//  - burst_cnt:
//      increments on an m1 grant while lock_own=1 and m0_req=1; saturates at BURST_MAX
//      clears on any m0 grant or when lock_own falls
//  - Reaching BURST_MAX forces exactly one m0 grant; the m1 lock may then resume.
//  - Read latency: a read granted in cycle N gives mX_rvalid=1 in N+1 only.
//  - A granted write never raises rvalid.
//  - Back-to-back reads from alternating owners produce alternating rvalids every cycle.
//  - m1 with m1_lock=1 and m1_req=0: lock_own holds, m0 is granted freely.
//  - Asynchronous reset mid-read clears pending rvalid; the read result is discarded.
//  - No write/read hazard logic. ram_dual port A and port B collisions are owned by software.
// STRUCTURE
//  - ram_arb_defs.vh: localparams ARB_M0=1'b0, ARB_M1=1'b1 (owner encoding), shared with the loader.
//  - One sub-module, arb_rr2: 2-way round-robin picker with lock and burst counter (BURST_MAX).
//  - Top level holds the address/data mux and the rvalid pipeline register.
// TESTING
//  1. Reset, then m0 reads addr 0x010 (mem=0x1234):
//     m0_gnt in cycle 0; m0_rvalid=1 with rdata=0x1234 in cycle 1 only.
//  2. m0 and m1 both reading continuously, no lock:
//     grants alternate m0,m1,m0,m1; rvalids alternate one cycle later.
//  3. m1_lock=1, both requesting, BURST_MAX=8:
//     8 m1 grants, 1 m0 grant, then 8 m1 grants; repeats.
//  4. m1 writes 0xBEEF to 0x0FF (ram_we=1, no rvalid); next cycle m0 reads 0x0FF -> rdata=0xBEEF.
//  5. Assert reset in the cycle after an m1 read grant:
//     m1_rvalid stays 0; all gnt=0 while reset is high; first grant after release goes to m0.
//  6. Idle (no req) for 10 cycles: ram_we=0, no gnt, no rvalid; last/lock_own unchanged.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: owner encoding and grant/lock enums.
package ram_port_arbiter_pkg;

    // Owner encoding, also used by the serial loader.
    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_M0   = 2'd1,
        GNT_M1   = 2'd2
    } gnt_t;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/ram_port_arbiter_arb_rr2.sv
// Two-way round-robin picker. m1 may hold the port with a lock; a burst counter
// bounds how many locked m1 grants m0 has to sit through.
//
//  state     | meaning
//  LOCK_FREE | plain round-robin between m0 and m1
//  LOCK_HELD | m1 keeps winning ties until burst_cnt reaches BURST_MAX
module arb_rr2
    import ram_port_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);

    localparam int CW = $clog2(BURST_MAX + 1);

    logic          last;
    logic          last_nxt;
    lock_state_t   lock_own;
    lock_state_t   lock_nxt;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_nxt;
    gnt_t          pick;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        pick = GNT_NONE;
        if (reset) begin
            pick = GNT_NONE;
        end else if (req0 && !req1) begin
            pick = GNT_M0;
        end else if (req1 && !req0) begin
            pick = GNT_M1;
        end else if (req0 && req1) begin
            if (lock_own == LOCK_HELD && burst_cnt < CW'(BURST_MAX)) begin
                pick = GNT_M1;
            end else if (last == ARB_M0) begin
                pick = GNT_M1;
            end else begin
                pick = GNT_M0;
            end
        end
    end

    assign gnt0 = (pick == GNT_M0);
    assign gnt1 = (pick == GNT_M1);

    // Next owner, lock and burst count. The m1 grant that takes the lock while
    // m0 is waiting counts as the first grant of the burst, so m0 waits at most
    // BURST_MAX locked grants.
    always_comb begin
        last_nxt  = last;
        lock_nxt  = lock_own;
        burst_nxt = burst_cnt;
        if (pick == GNT_M0) begin
            last_nxt  = ARB_M0;
            lock_nxt  = LOCK_FREE;
            burst_nxt = '0;
        end else if (pick == GNT_M1) begin
            last_nxt = ARB_M1;
            lock_nxt = lock1 ? LOCK_HELD : LOCK_FREE;
            if (!lock1) begin
                burst_nxt = '0;
            end else if (req0 && burst_cnt < CW'(BURST_MAX)) begin
                burst_nxt = burst_cnt + CW'(1);
            end
        end
    end

    // State register; after reset m0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= ARB_M1;
            lock_own  <= LOCK_FREE;
            burst_cnt <= '0;
        end else begin
            last      <= last_nxt;
            lock_own  <= lock_nxt;
            burst_cnt <= burst_nxt;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares port B of ram_dual between the J1 data bus (m0) and the loader (m1).
// Holds the address/data mux and tracks the RAM's one-cycle read latency.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int LOG2ABITS = 12,
    parameter int DWIDTH    = 16,
    parameter int BURST_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [LOG2ABITS-1:0] m0_addr,
    input  logic [DWIDTH-1:0]    m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [LOG2ABITS-1:0] m1_addr,
    input  logic [DWIDTH-1:0]    m1_wdata,
    input  logic                 m1_lock,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [LOG2ABITS-1:0] ram_addr,
    output logic [DWIDTH-1:0]    ram_wdata,
    output logic                 ram_we,
    input  logic [DWIDTH-1:0]    ram_rdata,
    output logic [DWIDTH-1:0]    rdata
);

    arb_rr2 #(
        .BURST_MAX(BURST_MAX)
    ) u_arb (
        .clk  (clk),
        .reset(reset),
        .req0 (m0_req),
        .req1 (m1_req),
        .lock1(m1_lock),
        .gnt0 (m0_gnt),
        .gnt1 (m1_gnt)
    );

    // Route the granted requester to the RAM; idle cycles park on m0 with writes off.
    always_comb begin
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
        ram_we    = 1'b0;
        if (m1_gnt) begin
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            ram_we    = m1_we;
        end else if (m0_gnt) begin
            ram_we = m0_we;
        end
    end

    // Flag the cycle in which the registered RAM output belongs to each requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
        end
    end

    assign rdata = ram_rdata;

endmodule
